// File: rtl/muldiv_unit_if.sv
// Handshake/data bundle between the issuing pipeline and muldiv_unit.
// master drives the request; slave is the multiply/divide engine.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] Input1toMD;
  logic [WIDTH-1:0] Input2toMD;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] low;

  modport master (
    output start, op, Input1toMD, Input2toMD,
    input  busy, done, div_by_zero, hi, low
  );

  modport slave (
    input  start, op, Input1toMD, Input2toMD,
    output busy, done, div_by_zero, hi, low
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add mul, restoring div.
// Define MULDIV_MADD_EN to make op 1 accumulate into {hi,low}.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] p;
  logic               neg_q;
  logic               neg_r;
  logic               busy;
  logic               done;
  logic               dz;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   low;

  logic               sgn;
  logic               s1;
  logic               s2;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     sub;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               is_div;
  logic               zero;

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_by_zero = dz;
  assign bus.hi          = hi;
  assign bus.low         = low;

  assign sgn   = (bus.op == 2'd1) || (bus.op == 2'd2);
  assign s1    = sgn & bus.Input1toMD[WIDTH-1];
  assign s2    = sgn & bus.Input2toMD[WIDTH-1];
  assign a_mag = s1 ? -bus.Input1toMD : bus.Input1toMD;
  assign b_mag = s2 ? -bus.Input2toMD : bus.Input2toMD;

  // mul: p = {partial, multiplier}; div: p = {remainder, quotient}
  assign add_sum = {1'b0, p[2*WIDTH-1:WIDTH]}
                 + (p[0] ? {1'b0, m} : '0);
  assign shl     = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign sub     = shl - {1'b0, m};

  assign prod = neg_q ? -p : p;
  assign acc  = {hi, low} + prod;
  assign quo  = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign rem  = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];

  assign is_div = op_r[1];
  assign zero   = (m == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= '0;
      m     <= '0;
      p     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
      hi    <= '0;
      low   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            dz    <= 1'b0;
            op_r  <= bus.op;
            neg_q <= s1 ^ s2;
            neg_r <= s1;
            if (bus.op[1]) begin
              m <= b_mag;
              p <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              m <= a_mag;
              p <= {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
        RUN: begin
          if (is_div && zero) begin
            dz    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == CW'(WIDTH)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            unique case (op_r)
              2'd0: {hi, low} <= prod;
`ifdef MULDIV_MADD_EN
              2'd1: {hi, low} <= acc;
`else
              2'd1: {hi, low} <= prod;
`endif
              default: begin
                hi  <= rem;
                low <= quo;
              end
            endcase
          end else begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
              if (sub[WIDTH])
                p <= {shl[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
              else
                p <= {sub[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
            end else begin
              p <= {add_sum, p[WIDTH-1:1]};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MULDIV_MADD_EN
  logic unused_acc;
  assign unused_acc = ^acc;
`endif
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, decoupled monitor.
module tb_muldiv_unit;
  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  bit   prev_done;

  typedef struct {
    int          edge_n;
    logic [31:0] hi;
    logic [31:0] low;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor: pops an expectation on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && prev_done)
      chk("done_one_cycle", 64'(bus.done), 64'd0);
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("done_edge", 64'(cyc), 64'(e.edge_n));
        chk("hi", 64'(bus.hi), 64'(e.hi));
        chk("low", 64'(bus.low), 64'(e.low));
        chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dz));
        chk("busy_at_done", 64'(bus.busy), 64'd0);
      end
    end
    prev_done = bus.done;
  end

  // called at a negedge; returns at the negedge after E0
  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit push,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic edz, input int lat);
    exp_t e;
    bus.start      = 1'b1;
    bus.op         = o;
    bus.Input1toMD = a;
    bus.Input2toMD = b;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    chk("dz_cleared_on_start", 64'(bus.div_by_zero), 64'd0);
    if (push) begin
      e.edge_n = cyc + lat;
      e.hi     = eh;
      e.low    = el;
      e.dz     = edz;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    cyc            = 0;
    prev_done      = 1'b0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.op         = 2'd0;
    bus.Input1toMD = '0;
    bus.Input2toMD = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_low", 64'(bus.low), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dz", 64'(bus.div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'd0, 32'hFFFF_FFFF, 32'h2, 1'b1,
          32'h1, 32'hFFFF_FFFE, 1'b0, 33);
    wait_done();
    // back-to-back: started the cycle after done
`ifdef MULDIV_MADD_EN
    issue(2'd1, 32'hFFFF_FFFF, 32'h3, 1'b1,
          32'h1, 32'hFFFF_FFFB, 1'b0, 33);
`else
    issue(2'd1, 32'hFFFF_FFFF, 32'h3, 1'b1,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
`endif
    wait_done();
    issue(2'd2, 32'hFFFF_FFF9, 32'h2, 1'b1,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    wait_done();
    issue(2'd3, 32'hFFFF_FFF9, 32'h2, 1'b1,
          32'h1, 32'h7FFF_FFFC, 1'b0, 33);
    wait_done();
    issue(2'd3, 32'h7, 32'h0, 1'b1,
          32'h1, 32'h7FFF_FFFC, 1'b1, 1);
    wait_done();
    issue(2'd0, 32'h3, 32'h5, 1'b1,
          32'h0, 32'hF, 1'b0, 33);
    wait_done();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
          32'h0, 32'h8000_0000, 1'b0, 33);
    wait_done();
    issue(2'd2, 32'd100, 32'hFFFF_FFF9, 1'b1,
          32'h2, 32'hFFFF_FFF2, 1'b0, 33);
    wait_done();

    // start pulsed at E5 of a running mul must be ignored
    issue(2'd0, 32'h1234_5678, 32'h10, 1'b1,
          32'h1, 32'h2345_6780, 1'b0, 33);
    repeat (4) @(negedge clk);
    bus.start      = 1'b1;
    bus.op         = 2'd2;
    bus.Input1toMD = 32'h1;
    bus.Input2toMD = 32'h1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_during_ignored", 64'(bus.busy), 64'd1);
    wait_done();
    @(negedge clk);

    // reset at E10 of a div: aborts, no done, no partial result
    issue(2'd2, 32'd100, 32'd3, 1'b0, '0, '0, 1'b0, 33);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_hi", 64'(bus.hi), 64'd0);
    chk("mid_rst_low", 64'(bus.low), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_dz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_hi", 64'(bus.hi), 64'd0);
    chk("post_rst_low", 64'(bus.low), 64'd0);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);

    issue(2'd3, 32'd9, 32'd4, 1'b1,
          32'h1, 32'h2, 1'b0, 33);
    wait_done();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; hi and low are each WIDTH bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port op, input, 2 bits: 0 = mul (unsigned), 1 = madd (signed accumulate), 2 = div (signed), 3 = divu (unsigned).
REQ-006 The block SHALL have port Input1toMD, input, WIDTH bits: multiplicand or dividend.
REQ-007 The block SHALL have port Input2toMD, input, WIDTH bits: multiplier or divisor.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port div_by_zero, output, 1 bit: the last div or divu had a zero divisor.
REQ-011 The block SHALL have ports hi and low, both output, WIDTH bits each: registered HI and LO results, consumed by the ALU's hi/low path and by mfhi/mflo.

Function
REQ-012 The block SHALL implement an FSM with states IDLE and RUN, plus a WIDTH-cycle iteration counter.
REQ-013 start SHALL be accepted only at a rising edge (E0) where the state is IDLE and start=1; operands and op are captured at E0, busy goes high after E0, and the state goes to RUN.
REQ-014 A start sampled high while busy is high SHALL be ignored, with no effect on the operation in progress or its result.
REQ-015 RUN SHALL perform one iteration per edge (shift-add multiply or restoring divide on magnitudes), WIDTH iterations in total.
REQ-016 Completion, nonzero divisor: hi/low SHALL be written, done set high and busy set low at edge E(WIDTH+1); the state returns to IDLE.
REQ-017 done SHALL be high for exactly one cycle, and a start sampled at the next edge SHALL be accepted, allowing back-to-back operations.
REQ-018 mul SHALL set {hi,low} to the unsigned 2*WIDTH-bit product.
REQ-019 madd SHALL set {hi,low} to {hi,low} plus the signed product, modulo 2^(2*WIDTH).
REQ-020 div SHALL set low to the quotient truncated toward zero and hi to the remainder, whose sign follows the dividend; divu does the same with unsigned operands.
REQ-021 div of -2^(WIDTH-1) by -1 SHALL give low = 0x80000000 and hi = 0 (WIDTH=32).
REQ-022 Divisor zero (div or divu): at E1, done=1 and div_by_zero=1, hi/low unchanged, busy low; no RUN iterations occur.
REQ-023 div_by_zero SHALL be cleared at the next accepted start.
REQ-024 hi and low SHALL hold their values between completions.

Reset
REQ-025 When rst_n=0, the block SHALL immediately force: state IDLE, counter 0, busy 0, done 0, div_by_zero 0, hi 0, low 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation, produce no done pulse, and leave no partial result.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-028 The macro MULDIV_MADD_EN SHALL control op 1: when defined, op 1 is madd per REQ-019.
REQ-029 When MULDIV_MADD_EN is not defined, op 1 SHALL perform a signed multiply that overwrites {hi,low} with no accumulation, at the same latency.

Verification
REQ-030 Scenario: mul, 0xFFFFFFFF x 0x00000002 -> done exactly at E33; hi = 0x00000001; low = 0xFFFFFFFE; busy low at E33.
REQ-031 Scenario: from hi:low = 0x00000001:0xFFFFFFFE, madd of 0xFFFFFFFF (-1) x 3 -> hi = 0x00000001, low = 0xFFFFFFFB; without MULDIV_MADD_EN -> hi = 0xFFFFFFFF, low = 0xFFFFFFFD.
REQ-032 Scenario: div, -7 / 2 -> low = 0xFFFFFFFD, hi = 0xFFFFFFFF; divu, 0xFFFFFFF9 / 2 -> low = 0x7FFFFFFC, hi = 0x00000001.
REQ-033 Scenario: divu, 7 / 0 -> done and div_by_zero at E1, hi/low unchanged; the next accepted start clears div_by_zero.
REQ-034 Scenario: start pulsed at E5 of a running mul -> ignored, the original result appears at E33; start re-asserted the cycle after done -> accepted.
REQ-035 Scenario: rst_n pulsed low at E10 of a div -> all outputs 0 immediately, no done pulse; hi/low remain 0 until the next completion.
